// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// regfile_wb_arbiter: shares the register-file write port between a priority
// pipeline writeback (A) and a starvation-bounded multi-cycle unit (B).
// Optional destination scoreboard enabled by REGFILE_WB_SCOREBOARD_EN.
// Revision: 1.0
// ============================================================================
module regfile_wb_arbiter #(
  parameter int width    = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [2:0]       a_reg,
  input  logic [width-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [2:0]       b_reg,
  input  logic [width-1:0] b_data,
  output logic             b_ready,
  input  logic             rsv_valid,
  input  logic [2:0]       rsv_reg,
  output logic             writeEn,
  output logic [2:0]       writeRegSel,
  output logic [width-1:0] writeData,
  output logic [7:0]       busy,
  output logic             err
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

  typedef enum logic [0:0] {
    PRIO_A  = 1'b0,
    FORCE_B = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               write_en_q, write_en_d;
  logic [2:0]         write_sel_q, write_sel_d;
  logic [width-1:0]   write_data_q, write_data_d;
  logic [7:0]         busy_q, busy_d;
  logic               err_q, err_d;
  logic               a_xfer, b_xfer;
  logic               proto_err, sb_err;

  // Ready depends only on state and a_valid so B can never gate its own grant.
  always_comb begin
    a_ready = (state_q == PRIO_A);
    b_ready = (state_q == PRIO_A) ? ~a_valid : 1'b1;
  end

  assign a_xfer = a_valid & a_ready;
  assign b_xfer = b_valid & b_ready;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    proto_err  = 1'b0;
    case (state_q)
      PRIO_A: begin
        if (b_xfer) begin
          wait_cnt_d = '0;
        end else if (b_valid) begin
          if (wait_cnt_q == WAIT_LAST) begin
            state_d    = FORCE_B;
            wait_cnt_d = '0;
          end else begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
          end
        end
      end
      FORCE_B: begin
        state_d    = PRIO_A;
        wait_cnt_d = '0;
        proto_err  = ~b_valid;
      end
      default: begin
        state_d    = PRIO_A;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    write_en_d   = a_xfer | b_xfer;
    write_sel_d  = write_sel_q;
    write_data_d = write_data_q;
    if (a_xfer) begin
      write_sel_d  = a_reg;
      write_data_d = a_data;
    end else if (b_xfer) begin
      write_sel_d  = b_reg;
      write_data_d = b_data;
    end
  end

`ifdef REGFILE_WB_SCOREBOARD_EN
  // Set is applied after clear so a same-edge reserve of the retiring register wins.
  always_comb begin
    busy_d = busy_q;
    if (b_xfer) busy_d[b_reg] = 1'b0;
    if (rsv_valid) busy_d[rsv_reg] = 1'b1;
    sb_err = (rsv_valid & busy_q[rsv_reg] & ~(b_xfer & (b_reg == rsv_reg)))
           | (b_xfer & ~busy_q[b_reg])
           | (a_xfer & busy_q[a_reg]);
  end
`else
  logic unused_rsv;
  assign unused_rsv = ^{rsv_valid, rsv_reg};
  assign busy_d     = 8'h00;
  assign sb_err     = 1'b0;
`endif

  assign err_d = proto_err | sb_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= PRIO_A;
      wait_cnt_q   <= '0;
      write_en_q   <= 1'b0;
      write_sel_q  <= 3'd0;
      write_data_q <= '0;
      busy_q       <= 8'h00;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      write_en_q   <= write_en_d;
      write_sel_q  <= write_sel_d;
      write_data_q <= write_data_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign writeEn     = write_en_q;
  assign writeRegSel = write_sel_q;
  assign writeData   = write_data_q;
  assign busy        = busy_q;
  assign err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// tb_regfile_wb_arbiter: directed stimulus with a write-port scoreboard queue.
// Revision: 1.0
// ============================================================================
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_valid = 1'b0, b_valid = 1'b0, rsv_valid = 1'b0;
  logic [2:0]  a_reg = 3'd0, b_reg = 3'd0, rsv_reg = 3'd0;
  logic [15:0] a_data = 16'h0, b_data = 16'h0;
  logic        a_ready, b_ready, writeEn, err;
  logic [2:0]  writeRegSel;
  logic [15:0] writeData;
  logic [7:0]  busy;

  typedef struct packed {
    logic [2:0]  r;
    logic [15:0] d;
  } wr_t;

  wr_t         exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [2:0]  last_reg = 3'd0;
  logic [15:0] last_data = 16'h0;
  logic [15:0] adat;

  regfile_wb_arbiter #(.width(16), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
    .rsv_valid(rsv_valid), .rsv_reg(rsv_reg),
    .writeEn(writeEn), .writeRegSel(writeRegSel), .writeData(writeData),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_valid = 1'b0; b_valid = 1'b0; rsv_valid = 1'b0;
  endtask

  task automatic push(input logic [2:0] r, input logic [15:0] d);
    exp_q.push_back({r, d});
  endtask

  // Monitor: every write must match the next expected entry; idle cycles must hold.
  always @(negedge clk) begin
    wr_t e;
    if (!rst) begin
      last_reg  = 3'd0;
      last_data = 16'h0;
    end else if (writeEn) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {31'd0, writeEn}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_sel", {29'd0, writeRegSel}, {29'd0, e.r});
        chk("wr_data", {16'd0, writeData}, {16'd0, e.d});
        last_reg  = e.r;
        last_data = e.d;
      end
    end else begin
      chk("hold_sel", {29'd0, writeRegSel}, {29'd0, last_reg});
      chk("hold_data", {16'd0, writeData}, {16'd0, last_data});
    end
  end

  initial begin
    // Reset state, asserted asynchronously before any clock edge.
    #2 rst = 1'b0;
    #1;
    chk("rst_writeEn", writeEn, 0);
    chk("rst_sel", writeRegSel, 0);
    chk("rst_data", writeData, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_a_ready", a_ready, 1);
    #9 rst = 1'b1;
    cyc();

    // A only
    a_valid = 1'b1; a_reg = 3'd3; a_data = 16'hBEEF;
    #1;
    chk("aonly_a_ready", a_ready, 1);
    chk("aonly_b_ready", b_ready, 0);
    push(3'd3, 16'hBEEF);
    cyc();
    idle();
    chk("aonly_writeEn", writeEn, 1);
    cyc();

    // Starvation: B forced in cycle 4, A resumes in cycle 5
    adat = 16'hA000;
    for (int i = 0; i < 6; i++) begin
      a_valid = 1'b1; a_reg = 3'd1; a_data = adat;
      b_valid = (i <= 4); b_reg = 3'd5; b_data = 16'h1234;
      #1;
      chk($sformatf("starve_a_ready_c%0d", i), a_ready, (i != 4));
      chk($sformatf("starve_b_ready_c%0d", i), b_ready, (i == 4));
`ifndef REGFILE_WB_SCOREBOARD_EN
      chk($sformatf("starve_err_c%0d", i), err, 0);
`endif
      if (i == 4) push(3'd5, 16'h1234);
      else begin
        push(3'd1, adat);
        adat = adat + 16'd1;
      end
      cyc();
    end
    idle();
    cyc();

    // Wait counter clears on a B transfer: second B needs four fresh refusals
    adat = 16'hC000;
    for (int i = 0; i < 9; i++) begin
      a_valid = (i != 2); a_reg = 3'd4; a_data = adat;
      b_valid = (i <= 7); b_reg = 3'd6; b_data = (i <= 2) ? 16'h0B01 : 16'h0B02;
      #1;
      chk($sformatf("clr_a_ready_c%0d", i), a_ready, (i != 7));
      chk($sformatf("clr_b_ready_c%0d", i), b_ready, (i == 2) || (i == 7));
      if (i == 2) push(3'd6, 16'h0B01);
      else if (i == 7) push(3'd6, 16'h0B02);
      else begin
        push(3'd4, adat);
        adat = adat + 16'd1;
      end
      cyc();
    end
    idle();
    cyc();

    // Idle B: granted in the same cycle
    b_valid = 1'b1; b_reg = 3'd7; b_data = 16'h5A5A;
    #1;
    chk("idleb_b_ready", b_ready, 1);
    push(3'd7, 16'h5A5A);
    cyc();
    idle();
    chk("idleb_writeEn", writeEn, 1);
    cyc();

    // FORCE_B with b_valid dropped: err pulse, back to PRIO_A
    adat = 16'hD000;
    for (int i = 0; i < 7; i++) begin
      a_valid = 1'b1; a_reg = 3'd1; a_data = adat;
      b_valid = (i <= 3); b_reg = 3'd5; b_data = 16'h7777;
      #1;
      chk($sformatf("proto_a_ready_c%0d", i), a_ready, (i != 4));
      chk($sformatf("proto_b_ready_c%0d", i), b_ready, (i == 4));
      chk($sformatf("proto_err_c%0d", i), err, (i == 5));
      if (i != 4) begin
        push(3'd1, adat);
        adat = adat + 16'd1;
      end
      cyc();
    end
    idle();
    cyc();
    cyc();

`ifdef REGFILE_WB_SCOREBOARD_EN
    rsv_valid = 1'b1; rsv_reg = 3'd2;
    cyc(); idle();
    chk("sb_rsv_busy", busy, 8'h04);
    chk("sb_rsv_err", err, 0);
    b_valid = 1'b1; b_reg = 3'd2; b_data = 16'h2222;
    #1;
    chk("sb_b_ready", b_ready, 1);
    push(3'd2, 16'h2222);
    cyc(); idle();
    chk("sb_clear_writeEn", writeEn, 1);
    chk("sb_clear_busy", busy, 8'h00);
    chk("sb_clear_err", err, 0);
    rsv_valid = 1'b1; rsv_reg = 3'd2;
    cyc(); idle();
    chk("sb_rsv2_busy", busy, 8'h04);
    rsv_valid = 1'b1; rsv_reg = 3'd2; b_valid = 1'b1; b_reg = 3'd2; b_data = 16'h2233;
    push(3'd2, 16'h2233);
    cyc(); idle();
    chk("sb_same_busy", busy, 8'h04);
    chk("sb_same_err", err, 0);
    rsv_valid = 1'b1; rsv_reg = 3'd2;
    cyc(); idle();
    chk("sb_dup_err", err, 1);
    chk("sb_dup_busy", busy, 8'h04);
    cyc();
    chk("sb_dup_err_one_cycle", err, 0);
    b_valid = 1'b1; b_reg = 3'd4; b_data = 16'h4444;
    push(3'd4, 16'h4444);
    cyc(); idle();
    chk("sb_bnotbusy_err", err, 1);
    chk("sb_bnotbusy_busy", busy, 8'h04);
    a_valid = 1'b1; a_reg = 3'd2; a_data = 16'hAAAA;
    push(3'd2, 16'hAAAA);
    cyc(); idle();
    chk("sb_waw_err", err, 1);
    chk("sb_waw_writeEn", writeEn, 1);
    chk("sb_waw_busy", busy, 8'h04);
    b_valid = 1'b1; b_reg = 3'd2; b_data = 16'h2244;
    push(3'd2, 16'h2244);
    cyc(); idle();
    chk("sb_final_busy", busy, 8'h00);
    chk("sb_final_err", err, 0);
    cyc();
`else
    rsv_valid = 1'b1; rsv_reg = 3'd2;
    cyc(); idle();
    chk("nosb_rsv_busy", busy, 8'h00);
    chk("nosb_rsv_err", err, 0);
    b_valid = 1'b1; b_reg = 3'd2; b_data = 16'h2222;
    push(3'd2, 16'h2222);
    cyc(); idle();
    chk("nosb_b_err", err, 0);
    chk("nosb_b_busy", busy, 8'h00);
    cyc();
`endif

    // Reset mid-traffic while in FORCE_B
    adat = 16'hE000;
    for (int i = 0; i < 4; i++) begin
      a_valid = 1'b1; a_reg = 3'd1; a_data = adat;
      b_valid = 1'b1; b_reg = 3'd5; b_data = 16'h9999;
      push(3'd1, adat);
      adat = adat + 16'd1;
      cyc();
    end
    chk("mid_force_a_ready", a_ready, 0);
    chk("mid_writeEn", writeEn, 1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    idle();
    #1;
    chk("arst_writeEn", writeEn, 0);
    chk("arst_sel", writeRegSel, 0);
    chk("arst_data", writeData, 0);
    chk("arst_busy", busy, 0);
    chk("arst_err", err, 0);
    chk("arst_a_ready", a_ready, 1);
    chk("arst_b_ready", b_ready, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    cyc();
    a_valid = 1'b1; b_valid = 1'b1; a_reg = 3'd0; a_data = 16'h0F0F;
    #1;
    chk("post_rst_a_ready", a_ready, 1);
    chk("post_rst_b_ready", b_ready, 0);
    push(3'd0, 16'h0F0F);
    cyc();
    idle();
    cyc();
    cyc();

    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
